// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to unsigned-binary converter.
// Digits are consumed most significant first, one per clock, with a
// multiply-by-ten-and-add accumulator. Bad digits and results that do not
// fit in OUTPUT_WIDTH bits are reported through o_Error alongside o_DV.
module bcd_to_bin #(
  parameter int DECIMAL_DIGITS = 7,
  parameter int OUTPUT_WIDTH   = 24
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_Start,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  output logic [OUTPUT_WIDTH-1:0]       o_Binary,
  output logic                          o_DV,
  output logic                          o_Busy,
  output logic                          o_Error
);

  localparam int BCD_W = DECIMAL_DIGITS * 4;
  // Four spare bits hold a full step (x10 + 9) of an in-range value, so any
  // overflow is always visible above bit OUTPUT_WIDTH-1 before it can wrap.
  localparam int ACC_W = OUTPUT_WIDTH + 4;
  localparam int CNT_W = $clog2(DECIMAL_DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIMAL_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [BCD_W-1:0]        shift_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    err_q;
  logic                    err_d;
  logic [3:0]              digit;
  logic                    digitBad;
  logic                    accOverflow;
  logic [OUTPUT_WIDTH-1:0] binary_q;
  logic                    dv_q;
  logic                    busy_q;
  logic                    error_q;

  // Next accumulator step: acc*10 + top digit, plus the sticky error update.
  always_comb begin
    digit       = shift_q[BCD_W-1 -: 4];
    digitBad    = (digit > 4'd9);
    acc_d       = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
    accOverflow = |acc_d[ACC_W-1:OUTPUT_WIDTH];
    err_d       = err_q | digitBad | accOverflow;
  end

  // Control FSM with registered outputs; results are loaded on the last digit.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      binary_q <= '0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dv_q <= 1'b0;
          if (i_Start) begin
            shift_q <= i_BCD;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end

        ACCUM: begin
          acc_q   <= acc_d;
          err_q   <= err_d;
          shift_q <= shift_q << 4;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q  <= DONE;
            dv_q     <= 1'b1;
            error_q  <= err_d;
            binary_q <= err_d ? '0 : acc_d[OUTPUT_WIDTH-1:0];
          end
        end

        DONE: begin
          dv_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          dv_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Binary = binary_q;
  assign o_DV     = dv_q;
  assign o_Busy   = busy_q;
  assign o_Error  = error_q;

endmodule
